// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundle for the cache-line burst adaptor: the upstream line request side
// and the downstream pmem beat side. The adaptor connects through "slave".
// The environment (arbiter plus memory) connects through "master".
interface cacheline_burst_adaptor_if #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32
);
    logic                          line_read;
    logic                          line_write;
    logic [ADDR_W-1:0]             line_address;
    logic [BEAT_W*BURST_LEN-1:0]   line_wdata;
    logic [BEAT_W*BURST_LEN-1:0]   line_rdata;
    logic                          line_resp;
    logic                          pmem_read;
    logic                          pmem_write;
    logic [ADDR_W-1:0]             pmem_address;
    logic [BEAT_W-1:0]             pmem_wdata;
    logic [BEAT_W-1:0]             pmem_rdata;
    logic                          pmem_resp;

    modport slave (
        input  line_read, line_write, line_address, line_wdata, pmem_rdata, pmem_resp,
        output line_rdata, line_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output line_read, line_write, line_address, line_wdata, pmem_rdata, pmem_resp,
        input  line_rdata, line_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Cache-line burst adaptor.
// It turns one line read or write from the cache arbiter into a BURST_LEN-beat pmem
// burst. The pmem strobe is held for the whole burst, and one beat moves per pmem_resp.
// Completion is signalled upstream with a single-cycle line_resp.
module cacheline_burst_adaptor #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cacheline_burst_adaptor_if.slave bus
);
    localparam int LINE_W     = BEAT_W * BURST_LEN;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [LINE_W-1:0]  wbuf_q;
    logic [LINE_W-1:0]  rbuf_q, rbuf_d;
    logic [LINE_W-1:0]  rdata_q;
    logic [BEAT_W-1:0]  wbeat;
    logic               last_beat;

    assign last_beat = (beat_cnt_q == LAST_BEAT);

    // State and beat counter registers; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next state: read wins over write in IDLE; gaps without pmem_resp hold state and count.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.line_read) begin
                    state_d = RD;
                end else if (bus.line_write) begin
                    state_d = WR;
                end
            end
            RD, WR: begin
                if (bus.pmem_resp) begin
                    if (last_beat) begin
                        state_d    = DONE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Beat steering: merge the incoming read beat into the line buffer and pick the outgoing write beat.
    always_comb begin
        rbuf_d = rbuf_q;
        wbeat  = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (k == int'(beat_cnt_q)) begin
                if (state_q == RD && bus.pmem_resp) begin
                    rbuf_d[k*BEAT_W +: BEAT_W] = bus.pmem_rdata;
                end
                if (state_q == WR) begin
                    wbeat = wbuf_q[k*BEAT_W +: BEAT_W];
                end
            end
        end
    end

    // Datapath: capture the request in IDLE only, collect read beats, and publish the line on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (bus.line_read) begin
                    addr_q <= bus.line_address & ALIGN_MASK;
                end else if (bus.line_write) begin
                    addr_q <= bus.line_address & ALIGN_MASK;
                    wbuf_q <= bus.line_wdata;
                end
            end
            if (state_q == RD && bus.pmem_resp) begin
                rbuf_q <= rbuf_d;
                if (last_beat) begin
                    rdata_q <= rbuf_d;
                end
            end
        end
    end

    assign bus.pmem_read    = (state_q == RD);
    assign bus.pmem_write   = (state_q == WR);
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wbeat;
    assign bus.line_resp    = (state_q == DONE);
    assign bus.line_rdata   = rdata_q;
endmodule
